// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives one 4-bit 74181-style ALU slice over WIDTH/4
// nibble steps, LSB nibble first. The active-low carry ripples between steps.
// Each nibble is held for SETTLE_CYCLES+1 cycles before F is captured.
// Done pulses once the assembled result and flags are valid.
// Optional feature: define ALU_SEQ_OVF_EN to add the signed-overflow output ovf.
module alu_nibble_sequencer #(
   parameter int WIDTH         = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout_b,
   output logic             zero,
   output logic             aeb,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [3:0]       alu_s,
   output logic             alu_m,
   output logic             alu_cnb,
   input  logic [3:0]       alu_f,
   input  logic             alu_cn4b,
   input  logic             alu_aeb
`ifdef ALU_SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NIB   = WIDTH / 4;
   localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   // Idle slice drive: logic mode, S=0011 forces F=0 on the slice.
   localparam logic [3:0] S_PARK = 4'b0011;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;     // operand nibbles not yet sent to the slice
   logic [WIDTH-1:0] result_cap;     // result with the current F nibble merged in
   logic [NIB_W-1:0] nib;
   logic [CNT_W-1:0] cnt;
   logic             aeb_acc;
   logic             capture, last;

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process evaluation order.
      if (!rstb) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode, capture strobes and the merged result word.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_nxt  = state;
      capture    = 1'b0;
      last       = 1'b0;
      result_cap = result;
      for (int i = 0; i < NIB; i++) begin
         if (nib == NIB_W'(i)) result_cap[4*i +: 4] = alu_f;
      end
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            capture = (cnt == CNT_W'(SETTLE_CYCLES));
            last    = capture && (nib == NIB_W'(NIB - 1));
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, slice drive, nibble capture and final flags.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_sh    <= '0;
         b_sh    <= '0;
         nib     <= '0;
         cnt     <= '0;
         aeb_acc <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cout_b  <= 1'b1;
         zero    <= 1'b0;
         aeb     <= 1'b0;
         alu_a   <= 4'h0;
         alu_b   <= 4'h0;
         alu_s   <= S_PARK;
         alu_m   <= 1'b1;
         alu_cnb <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  alu_a   <= a[3:0];
                  alu_b   <= b[3:0];
                  a_sh    <= a >> 4;
                  b_sh    <= b >> 4;
                  alu_s   <= s;
                  alu_m   <= m;
                  alu_cnb <= cin_b;
                  nib     <= '0;
                  cnt     <= '0;
                  aeb_acc <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ST_RUN: begin
               if (capture) begin
                  result  <= result_cap;
                  aeb_acc <= aeb_acc & alu_aeb;
                  alu_cnb <= alu_cn4b;
                  if (last) begin
                     cout_b  <= alu_cn4b;
                     zero    <= (result_cap == '0);
                     aeb     <= aeb_acc & alu_aeb;
                     done    <= 1'b1;
                     alu_a   <= 4'h0;
                     alu_b   <= 4'h0;
                     alu_s   <= S_PARK;
                     alu_m   <= 1'b1;
                     alu_cnb <= 1'b1;
                  end else begin
                     nib   <= nib + 1'b1;
                     cnt   <= '0;
                     alu_a <= a_sh[3:0];
                     alu_b <= b_sh[3:0];
                     a_sh  <= a_sh >> 4;
                     b_sh  <= b_sh >> 4;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: busy <= 1'b0;
            default: busy <= 1'b0;
         endcase
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic a_msb, b_msb, ovf_cap;

   // Signed overflow for add (S=1001) and subtract (S=0110) in arithmetic mode.
   always_comb begin
      ovf_cap = 1'b0;
      if (!alu_m && alu_s == 4'b1001)
         ovf_cap = (a_msb == b_msb) && (alu_f[3] != a_msb);
      else if (!alu_m && alu_s == 4'b0110)
         ovf_cap = (a_msb != b_msb) && (alu_f[3] != a_msb);
   end

   // Latch operand sign bits at accept; register ovf with the final capture.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == ST_IDLE && start) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (last) begin
         ovf <= ovf_cap;
      end
   end
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer. A behavioural 74181 slice is attached
// to the slice ports. It shows wrong outputs until its inputs have been steady
// for SETTLE_CYCLES cycles. A word-level model predicts each operation, and a
// per-cycle monitor compares the DUT against that model. Directed operations
// also check hand-computed results. Honours ALU_SEQ_OVF_EN.
module tb_alu_nibble_sequencer;

   localparam int W   = 16;
   localparam int SET = 2;
   localparam int NIB = W / 4;
   localparam int LAT = NIB * (SET + 1);

   logic          clk, rstb, start;
   logic [W-1:0]  a, b;
   logic [3:0]    s;
   logic          m, cin_b;
   logic          busy, done, cout_b, zero, aeb;
   logic [W-1:0]  result;
   logic [3:0]    alu_a, alu_b, alu_s, alu_f;
   logic          alu_m, alu_cnb, alu_cn4b, alu_aeb;
`ifdef ALU_SEQ_OVF_EN
   logic          ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_nibble_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SET)) dut (
      .clk(clk), .rstb(rstb), .start(start), .a(a), .b(b), .s(s), .m(m),
      .cin_b(cin_b), .busy(busy), .done(done), .result(result),
      .cout_b(cout_b), .zero(zero), .aeb(aeb), .alu_a(alu_a), .alu_b(alu_b),
      .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb), .alu_f(alu_f),
      .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb)
`ifdef ALU_SEQ_OVF_EN
      , .ovf(ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // 74181 (active-high data) slice: returns {cn4b, aeb, f}.
   function automatic logic [5:0] slice_fn(input logic [3:0] x, y, sel, input logic md, cnb);
      logic [3:0] t1, t2, lf, f;
      logic [4:0] sum;
      case (sel)
         4'b0000: begin t1 = x;       t2 = 4'h0;    lf = ~x;       end
         4'b0001: begin t1 = x | y;   t2 = 4'h0;    lf = ~(x | y); end
         4'b0010: begin t1 = x | ~y;  t2 = 4'h0;    lf = ~x & y;   end
         4'b0011: begin t1 = 4'hF;    t2 = 4'h0;    lf = 4'h0;     end
         4'b0100: begin t1 = x;       t2 = x & ~y;  lf = ~(x & y); end
         4'b0101: begin t1 = x | y;   t2 = x & ~y;  lf = ~y;       end
         4'b0110: begin t1 = x;       t2 = ~y;      lf = x ^ y;    end
         4'b0111: begin t1 = x & ~y;  t2 = 4'hF;    lf = x & ~y;   end
         4'b1000: begin t1 = x;       t2 = x & y;   lf = ~x | y;   end
         4'b1001: begin t1 = x;       t2 = y;       lf = ~(x ^ y); end
         4'b1010: begin t1 = x | ~y;  t2 = x & y;   lf = y;        end
         4'b1011: begin t1 = x & y;   t2 = 4'hF;    lf = x & y;    end
         4'b1100: begin t1 = x;       t2 = x;       lf = 4'hF;     end
         4'b1101: begin t1 = x | y;   t2 = x;       lf = x | ~y;   end
         4'b1110: begin t1 = x | ~y;  t2 = x;       lf = x | y;    end
         default: begin t1 = x;       t2 = 4'hF;    lf = x;        end
      endcase
      sum = {1'b0, t1} + {1'b0, t2} + {4'h0, ~cnb};
      f = md ? lf : sum[3:0];
      return {~sum[4], (f == 4'hF), f};
   endfunction

   typedef struct packed {
      logic         cout_b;
      logic         aeb;
      logic         zero;
      logic         ovf;
      logic [W-1:0] res;
   } exp_t;

   // Whole-word prediction: a chain of NIB slices with the carry rippled.
   function automatic exp_t ref_op(input logic [W-1:0] x, y, input logic [3:0] sel,
                                   input logic md, cinb);
      exp_t e;
      logic [5:0] o;
      logic cnb;
      cnb   = cinb;
      e.aeb = 1'b1;
      e.res = '0;
      for (int i = 0; i < NIB; i++) begin
         o     = slice_fn(4'(x >> (4*i)), 4'(y >> (4*i)), sel, md, cnb);
         e.res = e.res | (W'(o[3:0]) << (4*i));
         e.aeb = e.aeb & o[4];
         cnb   = o[5];
      end
      e.cout_b = cnb;
      e.zero   = (e.res == '0);
      e.ovf    = 1'b0;
      if (!md && sel == 4'b1001) e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      if (!md && sel == 4'b0110) e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      return e;
   endfunction

   // Slice instance: outputs are wrong until the inputs have settled.
   logic [5:0]  sl;
   logic [13:0] prev_in = '0;
   int          stab = 0;
   assign sl       = slice_fn(alu_a, alu_b, alu_s, alu_m, alu_cnb);
   assign alu_f    = (stab >= SET) ? sl[3:0] : ~sl[3:0];
   assign alu_aeb  = (stab >= SET) ? sl[4]   : ~sl[4];
   assign alu_cn4b = (stab >= SET) ? sl[5]   : ~sl[5];

   // Count cycles for which the slice inputs have been unchanged.
   always @(posedge clk) begin
      #1;
      if ({alu_a, alu_b, alu_s, alu_m, alu_cnb} !== prev_in) stab = 0;
      else stab++;
      prev_in = {alu_a, alu_b, alu_s, alu_m, alu_cnb};
   end

   // Model of the sequencer: mk is the cycle index since accept, -1 when idle.
   int           mk = -1;
   logic [W-1:0] r_a = '0, r_b = '0;
   logic [3:0]   r_s = '0;
   logic         r_m = 1'b0, r_cinb = 1'b1;
   exp_t         e_hold = '{cout_b: 1'b1, aeb: 1'b0, zero: 1'b0, ovf: 1'b0, res: '0};

   // Advance the model on each clock edge; asynchronous reset clears it.
   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         mk     = -1;
         e_hold = '{cout_b: 1'b1, aeb: 1'b0, zero: 1'b0, ovf: 1'b0, res: '0};
      end else if (mk < 0) begin
         if (start) begin
            mk = 0; r_a = a; r_b = b; r_s = s; r_m = m; r_cinb = cin_b;
         end
      end else if (mk == LAT) begin
         mk = -1;
      end else begin
         mk++;
         if (mk == LAT) e_hold = ref_op(r_a, r_b, r_s, r_m, r_cinb);
      end
   end

   // Compare DUT outputs with the model on every falling edge.
   always @(negedge clk) begin
      check("mon_busy", busy, mk >= 0);
      check("mon_done", done, mk == LAT);
      check("mon_cout_b", cout_b, e_hold.cout_b);
      check("mon_zero", zero, e_hold.zero);
      check("mon_aeb", aeb, e_hold.aeb);
`ifdef ALU_SEQ_OVF_EN
      check("mon_ovf", ovf, e_hold.ovf);
`endif
      if (mk < 0 || mk == LAT) begin
         check("mon_result", result, e_hold.res);
         check("mon_park", {alu_a, alu_b, alu_s, alu_m, alu_cnb}, {4'h0, 4'h0, 4'b0011, 1'b1, 1'b1});
      end else begin
         check("mon_alu_a", alu_a, 4'(r_a >> (4*(mk/(SET+1)))));
         check("mon_alu_b", alu_b, 4'(r_b >> (4*(mk/(SET+1)))));
         check("mon_alu_s", alu_s, r_s);
         check("mon_alu_m", alu_m, r_m);
         if (mk <= SET) check("mon_alu_cnb0", alu_cnb, r_cinb);
      end
   end

   task automatic issue(input logic [W-1:0] ia, ib, input logic [3:0] is, input logic im, icin);
      @(negedge clk);
      a = ia; b = ib; s = is; m = im; cin_b = icin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for done, counting falling edges; noisy mode pulses start and
   // scrambles the operand inputs while the operation runs.
   task automatic wait_done(input bit noisy, output int n);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (noisy) begin
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); s = 4'($urandom);
            m = 1'($urandom); cin_b = 1'($urandom);
         end
      end
      check("done_seen", done, 1'b1);
   endtask

   task automatic check_out(input string nm, input logic [W-1:0] er,
                            input logic ec, ez, ea, eo);
      check({nm, "_result"}, result, er);
      check({nm, "_cout_b"}, cout_b, ec);
      check({nm, "_zero"}, zero, ez);
      check({nm, "_aeb"}, aeb, ea);
`ifdef ALU_SEQ_OVF_EN
      check({nm, "_ovf"}, ovf, eo);
`else
      if (eo) begin end
`endif
   endtask

   initial begin
      int n;
      start = 1'b0; a = '0; b = '0; s = 4'h0; m = 1'b0; cin_b = 1'b1;
      rstb = 1'b1;
      #1 rstb = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_park", {alu_a, alu_b, alu_s, alu_m, alu_cnb}, {4'h0, 4'h0, 4'b0011, 1'b1, 1'b1});
      check_out("rst", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      rstb = 1'b1;

      issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
      wait_done(1'b0, n);
      check("add_latency", n, 12);
      check_out("add", 16'h2233, 1'b1, 1'b0, 1'b0, 1'b0);

      issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      wait_done(1'b0, n);
      check_out("add_wrap", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

      issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
      wait_done(1'b0, n);
      check_out("add_ovf", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);

      issue(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b0);
      wait_done(1'b0, n);
      check_out("sub_borrow", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);

      issue(16'hABCD, 16'hABCD, 4'b0110, 1'b0, 1'b1);
      wait_done(1'b0, n);
      check_out("sub_eq", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

      // Logic AND with start pulses and operand changes throughout the run.
      issue(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b1);
      wait_done(1'b1, n);
      check("logic_latency", n, 12);
      check_out("logic_and", 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);

      // start is held through DONE (ignored) and the following IDLE cycle (accepted).
      a = 16'h8000; b = 16'h0001; s = 4'b0110; m = 1'b0; cin_b = 1'b0; start = 1'b1;
      @(negedge clk);
      check("gap_busy", busy, 1'b0);
      check_out("gap_hold", 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", busy, 1'b1);
      wait_done(1'b0, n);
      check("b2b_latency", n, 12);
      check_out("b2b_sub", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset while nibble 2 is on the slice.
      issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      check("mid_alu_a", alu_a, 4'h2);
      #2 rstb = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_park", {alu_a, alu_b, alu_s, alu_m, alu_cnb}, {4'h0, 4'h0, 4'b0011, 1'b1, 1'b1});
      check_out("mid_rst", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rstb = 1'b1;

      issue(16'h0102, 16'h0304, 4'b1001, 1'b0, 1'b1);
      wait_done(1'b0, n);
      check("post_rst_latency", n, 12);
      check_out("post_rst_add", 16'h0406, 1'b1, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Upstream driver and downstream collector for a single 4-bit 74181-style ALU slice.
- Takes a WIDTH-bit operation, feeds the slice one nibble per step (LSB nibble first), and ripples the active-low carry between steps.
- Waits a programmable settle time for the slice's combinational delay, captures each F nibble, and presents the assembled result and flags with a done pulse.
- Lets the datapath run wide operations on one physical slice.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, at least 4. NIB = WIDTH/4.
- SETTLE_CYCLES, 2, extra clock cycles each nibble is held before F is sampled; at least 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select passed to slice.
- m  in  1  mode (1 = logic, 0 = arithmetic).
- cin_b  in  1  active-low carry into nibble 0.
- busy  out  1  high from accept until done cycle inclusive.
- done  out  1  one-cycle pulse when result/flags valid.
- result  out  WIDTH  assembled F.
- cout_b  out  1  active-low carry out of final nibble.
- zero  out  1  result == 0.
- aeb  out  1  AND of slice AEB over all nibbles.
- alu_a, alu_b  out  4  nibble to slice A/B.
- alu_s  out  4  to slice S.
- alu_m  out  1  to slice M.
- alu_cnb  out  1  to slice CNb.
- alu_f  in  4  slice F.
- alu_cn4b  in  1  slice CN4b.
- alu_aeb  in  1  slice A=B.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State IDLE; busy=0, done=0, result=0, cout_b=1, zero=0, aeb=0.
  - alu_a=0, alu_b=0, alu_s=4'b0011, alu_m=1, alu_cnb=1. These values force slice F=0.
  - Partial results are discarded.
- All outputs are registered.
- IDLE:
  - On an edge with start=1, latch a, b, s, m.
  - Drive alu_a/alu_b with nibble 0, alu_s=s, alu_m=m, alu_cnb=cin_b.
  - Set nib=0, cnt=0, busy=1, aeb accumulator=1; go to RUN.
- RUN:
  - cnt increments each edge.
  - On the edge where cnt==SETTLE_CYCLES, capture:
    - result[4*nib+3:4*nib] <= alu_f
    - aeb_acc <= aeb_acc & alu_aeb
    - alu_cnb <= alu_cn4b
  - If nib<NIB-1: nib++, cnt=0, drive the next nibble.
  - Else: cout_b <= alu_cn4b, zero <= (full result incl. final nibble == 0), aeb <= final accumulated value; go to DONE.
  - Nibble k therefore sits on the slice for exactly SETTLE_CYCLES+1 cycles.
- DONE:
  - done=1, busy=1 for one cycle; next edge goes to IDLE, busy=0.
  - result/cout_b/zero/aeb hold until the next accept.
  - In DONE, alu_* return to the reset values.
- Latency: done is high in the cycle after NIB*(SETTLE_CYCLES+1) edges following the accept edge. Defaults: 12 edges, done visible in cycle 13.
- start while busy or in DONE: ignored, no queueing. Earliest re-accept is the IDLE cycle after done.
- Carry is propagated identically in logic mode. M=1 makes the slice ignore it.
- Operand inputs a/b/s/m/cin_b may change after the accept without effect.
- X/Z on alu_f propagates into result; no masking.

Optional Feature:
- ALU_SEQ_OVF_EN defined: adds output port ovf (1 bit, reset 0, valid with done).
  - m=0, s=1001 (add): ovf = (a_msb==b_msb) & (result_msb!=a_msb).
  - m=0, s=0110 (subtract): ovf = (a_msb!=b_msb) & (result_msb!=a_msb).
  - Otherwise ovf=0.
  - Operand MSBs are taken from the latched operands.
- Not defined: no ovf port, no related logic.

Test Plan:
- Add: s=1001, m=0, cin_b=1, a=0x1234, b=0x0FFF -> result=0x2233, cout_b=1, zero=0, done exactly 12 edges after accept (defaults).
- Add with wrap: a=0xFFFF, b=0x0001, s=1001, m=0, cin_b=1 -> result=0x0000, cout_b=0, zero=1. With OVF_EN, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1.
- Subtract: s=0110, m=0, cin_b=0, a=0x0005, b=0x0007 -> result=0xFFFE, cout_b=1 (borrow). Same with cin_b=1, a=b=0xABCD -> result=0xFFFF, aeb=1.
- Logic: s=1011, m=1, a=0xF0F0, b=0xFF00 -> result=0xF000. Check alu_m=1 and alu_s=1011 on every nibble.
- Start pulses during RUN and DONE are ignored and the result is unchanged. A start in the IDLE cycle after done is accepted.
- rstb low at nibble 2 of an add -> all outputs at reset values immediately (async), state IDLE. A fresh start after release completes correctly.
